// File: rtl/disp_scheduler.sv
// Display arbiter: shares the seven-segment digit codes between a live client A
// and a timed, optionally blinking one-shot message from client B.
`ifndef BCD_BLANK
`define BCD_BLANK 5'h1F
`endif

module disp_scheduler #(
  parameter int NUM_DIGITS  = 4,
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int BLINK_DIV   = 12_500_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    a_req,
  input  logic [5*NUM_DIGITS-1:0] a_digits,
  input  logic                    b_req,
  input  logic [5*NUM_DIGITS-1:0] b_digits,
  input  logic                    blink_en,
  output logic                    b_ack,
  output logic [5*NUM_DIGITS-1:0] disp_code,
  output logic [1:0]              owner
);

  localparam int DW = 5 * NUM_DIGITS;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [DW-1:0] BLANK_ALL  = {NUM_DIGITS{`BCD_BLANK}};

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SHOW_A = 2'b01,
    SHOW_B = 2'b10
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_disp;
  logic [DW-1:0]   r_msg;
  logic [HW-1:0]   r_hold;
  logic [BW-1:0]   r_blink_cnt;
  logic            r_phase_on;
  logic            r_ack;

  state_t          w_next_state;
  logic [DW-1:0]   w_disp_next;
  logic [DW-1:0]   w_msg_next;
  logic [HW-1:0]   w_hold_next;
  logic [BW-1:0]   w_blink_next;
  logic            w_phase_next;
  logic            w_ack_next;

  // Next-state, counter and display-code computation
  always_comb begin
    w_next_state = r_state;
    w_disp_next  = BLANK_ALL;
    w_msg_next   = r_msg;
    w_hold_next  = r_hold;
    w_blink_next = r_blink_cnt;
    w_phase_next = r_phase_on;
    w_ack_next   = 1'b0;

    case (r_state)
      IDLE: begin
        if (b_req)      w_next_state = SHOW_B;
        else if (a_req) w_next_state = SHOW_A;
        else            w_next_state = IDLE;
      end
      SHOW_A: begin
        if (b_req)       w_next_state = SHOW_B;
        else if (!a_req) w_next_state = IDLE;
        else             w_next_state = SHOW_A;
      end
      SHOW_B: begin
        if (b_req)                    w_next_state = SHOW_B;
        else if (r_hold == HOLD_LAST) w_next_state = a_req ? SHOW_A : IDLE;
        else                          w_next_state = SHOW_B;
      end
      default: w_next_state = IDLE;
    endcase

    // Acceptance restarts the message with a fresh hold window and ON phase
    if (b_req) begin
      w_ack_next   = 1'b1;
      w_msg_next   = b_digits;
      w_hold_next  = {HW{1'b0}};
      w_blink_next = {BW{1'b0}};
      w_phase_next = 1'b1;
    end else if (r_state == SHOW_B) begin
      if (r_hold == HOLD_LAST) begin
        w_hold_next = {HW{1'b0}};
      end else begin
        w_hold_next = r_hold + HW'(1);
      end
      if (r_blink_cnt == BLINK_LAST) begin
        w_blink_next = {BW{1'b0}};
        w_phase_next = ~r_phase_on;
      end else begin
        w_blink_next = r_blink_cnt + BW'(1);
      end
    end else begin
      w_hold_next  = {HW{1'b0}};
      w_blink_next = {BW{1'b0}};
      w_phase_next = 1'b1;
    end

    case (w_next_state)
      SHOW_A: w_disp_next = a_digits;
      SHOW_B: begin
        if (w_phase_next || !blink_en) w_disp_next = w_msg_next;
        else                           w_disp_next = BLANK_ALL;
      end
      default: w_disp_next = BLANK_ALL;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_disp      <= BLANK_ALL;
      r_msg       <= BLANK_ALL;
      r_hold      <= {HW{1'b0}};
      r_blink_cnt <= {BW{1'b0}};
      r_phase_on  <= 1'b1;
      r_ack       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_disp      <= w_disp_next;
      r_msg       <= w_msg_next;
      r_hold      <= w_hold_next;
      r_blink_cnt <= w_blink_next;
      r_phase_on  <= w_phase_next;
      r_ack       <= w_ack_next;
    end
  end

  assign b_ack     = r_ack;
  assign disp_code = r_disp;
  assign owner     = r_state;

endmodule

// File: tb/tb_disp_scheduler.sv
// Bench for disp_scheduler: directed scenarios then random traffic, all checked
// against a message-age reference model.
`ifndef BCD_BLANK
`define BCD_BLANK 5'h1F
`endif

module tb_disp_scheduler;

  localparam int ND   = 4;
  localparam int HOLD = 8;
  localparam int DIV  = 2;
  localparam logic [19:0] BLANK_ALL = {ND{`BCD_BLANK}};
  localparam logic [19:0] MSG_ERR   = {5'h11, 5'h11, 5'h0E, `BCD_BLANK};
  localparam logic [19:0] MSG_GOOD  = {5'h0D, 5'h12, 5'h12, 5'h13};

  logic        clk = 1'b0;
  logic        rst, a_req, b_req, blink_en;
  logic [19:0] a_digits, b_digits, disp_code;
  logic        b_ack;
  logic [1:0]  owner;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: mode 0 idle, 1 live A, 2 message; age = cycles since acceptance
  int          m_mode = 0;
  int          m_age  = 0;
  logic [19:0] m_msg  = BLANK_ALL;
  logic [19:0] e_disp = BLANK_ALL;
  logic        e_ack  = 1'b0;

  disp_scheduler #(.NUM_DIGITS(ND), .HOLD_CYCLES(HOLD), .BLINK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .a_req(a_req), .a_digits(a_digits),
    .b_req(b_req), .b_digits(b_digits), .blink_en(blink_en),
    .b_ack(b_ack), .disp_code(disp_code), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_mode = 0;
      m_age  = 0;
      e_ack  = 1'b0;
    end else begin
      e_ack = b_req;
      if (b_req) begin
        m_mode = 2;
        m_msg  = b_digits;
        m_age  = 0;
      end else if (m_mode == 0) begin
        if (a_req) m_mode = 1;
      end else if (m_mode == 1) begin
        if (!a_req) m_mode = 0;
      end else begin
        m_age++;
        if (m_age == HOLD) m_mode = a_req ? 1 : 0;
      end
    end
    if (m_mode == 1)
      e_disp = a_digits;
    else if (m_mode == 2)
      e_disp = ((((m_age / DIV) % 2) == 0) || !blink_en) ? m_msg : BLANK_ALL;
    else
      e_disp = BLANK_ALL;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("disp_code", disp_code, e_disp);
    check("owner", {18'd0, owner}, 20'(m_mode));
    check("b_ack", {19'd0, b_ack}, {19'd0, e_ack});
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0; blink_en = 1'b0;
    a_digits = 20'h0; b_digits = 20'h0;

    // 1: reset state
    steps(2);
    rst = 1'b0;
    steps(2);

    // 2: live A value and 1-cycle follow
    a_req = 1'b1; a_digits = {5'd3, 5'd2, 5'd1, 5'd0};
    steps(2);
    a_digits = {5'd9, 5'd8, 5'd7, 5'd6};
    steps(2);

    // 3: one-shot message over A, no blink
    b_req = 1'b1; b_digits = MSG_ERR;
    step();
    b_req = 1'b0; b_digits = 20'hABCDE;
    steps(HOLD + 3);

    // 4: same with blink
    blink_en = 1'b1;
    b_req = 1'b1; b_digits = MSG_ERR;
    step();
    b_req = 1'b0;
    steps(HOLD + 3);

    // 5: re-request at hold cycle 5 restarts hold with new message
    b_req = 1'b1; b_digits = MSG_ERR;
    step();
    b_req = 1'b0;
    steps(5);
    b_req = 1'b1; b_digits = MSG_GOOD;
    step();
    b_req = 1'b0;
    steps(HOLD + 2);

    // 6: both requests from idle, then reset mid-message
    a_req = 1'b0; blink_en = 1'b0;
    steps(2);
    a_req = 1'b1; b_req = 1'b1; b_digits = MSG_GOOD;
    step();
    b_req = 1'b0;
    steps(3);
    rst = 1'b1;
    step();
    rst = 1'b0; a_req = 1'b0;
    steps(3);

    // held b_req is re-accepted every cycle; message expires to idle
    b_req = 1'b1; b_digits = MSG_ERR;
    steps(3);
    b_req = 1'b0;
    steps(HOLD + 2);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 15) == 0) a_req = ~a_req;
      a_digits = 20'($urandom);
      b_req    = ($urandom_range(0, 13) == 0);
      b_digits = 20'($urandom);
      if ($urandom_range(0, 40) == 0) blink_en = ~blink_en;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
